// File: rtl/motor_drive_sequencer.sv
// H-bridge sequencer: direction dead-time, soft-start PWM duty ramp and
// overcurrent handling with timed auto-retry and a permanent lockout.
module motor_drive_sequencer #(
  parameter int PWM_BITS    = 8,
  parameter int DEAD_CYCLES = 16,
  parameter int RAMP_STEP   = 4,
  parameter int RAMP_TICK   = 8,
  parameter int FAULT_HOLD  = 1000,
  parameter int MAX_RETRIES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          cmd,
  input  logic [PWM_BITS-1:0] duty_target,
  input  logic                oc_a,
  input  logic                oc_b,
  input  logic                clear_fault,
  output logic                OUT1,
  output logic                OUT2,
  output logic                OUT3,
  output logic                OUT4,
  output logic                OUTA,
  output logic                OUTB,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          state,
  output logic                fault,
  output logic [1:0]          retries
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int RW = $clog2(RAMP_TICK + 1);
  localparam int HW = $clog2(FAULT_HOLD + 1);

  localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEAD_CYCLES);
  localparam logic [RW-1:0]       TICK_LAST = RW'(RAMP_TICK - 1);
  localparam logic [HW-1:0]       HOLD_LOAD = HW'(FAULT_HOLD);
  localparam logic [1:0]          RETRY_LIM = 2'(MAX_RETRIES);
  localparam logic [PWM_BITS:0]   STEP_EXT  = (PWM_BITS + 1)'(RAMP_STEP);
  localparam logic [1:0]          CMD_STOP  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEAD    = 3'd1,
    S_RAMP    = 3'd2,
    S_RUN     = 3'd3,
    S_FAULT   = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  function automatic logic [3:0] f_pattern(input logic [1:0] dir);
    case (dir)
      2'b01:   return 4'b1111;
      2'b10:   return 4'b0110;
      2'b11:   return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  // One ramp increment: saturate at full scale, then clamp to the target.
  function automatic logic [PWM_BITS-1:0] f_ramp_step(input logic [PWM_BITS-1:0] cur,
                                                       input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS:0]   sum;
    logic [PWM_BITS-1:0] sat;
    sum = {1'b0, cur} + STEP_EXT;
    sat = sum[PWM_BITS] ? '1 : sum[PWM_BITS-1:0];
    return (sat > tgt) ? tgt : sat;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_dir, w_dir_nxt;
  logic [DW-1:0]       r_dead_cnt, w_dead_nxt;
  logic [RW-1:0]       r_ramp_cnt, w_ramp_nxt;
  logic [HW-1:0]       r_hold_cnt, w_hold_nxt;
  logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
  logic [1:0]          r_retries, w_retries_nxt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [3:0]          r_pins;
  logic                r_en;
  logic                r_fault;

  logic                w_oc;
  logic                w_active;
  logic [PWM_BITS-1:0] w_ramp_duty;
  logic [PWM_BITS-1:0] w_pwm_nxt;
  logic                w_drive_nxt;
  logic [3:0]          w_pins_nxt;
  logic                w_en_nxt;
  logic                w_fault_nxt;

  assign w_oc        = oc_a | oc_b;
  assign w_active    = (r_state == S_DEAD) || (r_state == S_RAMP) || (r_state == S_RUN);
  assign w_ramp_duty = f_ramp_step(r_duty, duty_target);
  assign w_pwm_nxt   = r_pwm_cnt + PWM_BITS'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_dead_nxt    = r_dead_cnt;
    w_ramp_nxt    = r_ramp_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_duty_nxt    = r_duty;
    w_retries_nxt = r_retries;
    if (w_oc && w_active) begin
      w_state_nxt   = S_FAULT;
      w_duty_nxt    = '0;
      w_dead_nxt    = '0;
      w_ramp_nxt    = '0;
      w_hold_nxt    = HOLD_LOAD;
      w_retries_nxt = (r_retries == 2'b11) ? r_retries : r_retries + 2'd1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_duty_nxt = '0;
          if (clear_fault) w_retries_nxt = '0;
          if (cmd != CMD_STOP) begin
            w_dir_nxt   = cmd;
            w_dead_nxt  = DEAD_LOAD;
            w_state_nxt = S_DEAD;
          end
        end
        S_DEAD: begin
          w_duty_nxt = '0;
          if (clear_fault) w_retries_nxt = '0;
          if (cmd == CMD_STOP) begin
            w_dead_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else if (cmd != r_dir) begin
            w_dir_nxt  = cmd;
            w_dead_nxt = DEAD_LOAD;
          end else if (r_dead_cnt <= DW'(1)) begin
            w_dead_nxt  = '0;
            w_ramp_nxt  = '0;
            w_state_nxt = S_RAMP;
          end else begin
            w_dead_nxt = r_dead_cnt - DW'(1);
          end
        end
        S_RAMP, S_RUN: begin
          if (clear_fault) w_retries_nxt = '0;
          if (cmd == CMD_STOP) begin
            w_duty_nxt  = '0;
            w_ramp_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else if (cmd != r_dir) begin
            // Any direction change goes back through a full dead-time window.
            w_duty_nxt  = '0;
            w_ramp_nxt  = '0;
            w_dir_nxt   = cmd;
            w_dead_nxt  = DEAD_LOAD;
            w_state_nxt = S_DEAD;
          end else if (duty_target < r_duty) begin
            w_duty_nxt  = duty_target;
            w_state_nxt = S_RUN;
          end else if (r_state == S_RUN) begin
            if (duty_target > r_duty) begin
              w_ramp_nxt  = '0;
              w_state_nxt = S_RAMP;
            end
          end else if (duty_target == r_duty) begin
            w_state_nxt = S_RUN;
          end else if (r_ramp_cnt == TICK_LAST) begin
            w_ramp_nxt = '0;
            w_duty_nxt = w_ramp_duty;
            if (w_ramp_duty == duty_target) w_state_nxt = S_RUN;
          end else begin
            w_ramp_nxt = r_ramp_cnt + RW'(1);
          end
        end
        S_FAULT: begin
          w_duty_nxt = '0;
          if (r_hold_cnt <= HW'(1)) begin
            w_hold_nxt  = '0;
            w_state_nxt = (r_retries >= RETRY_LIM) ? S_LOCKOUT : S_IDLE;
          end else begin
            w_hold_nxt = r_hold_cnt - HW'(1);
          end
        end
        S_LOCKOUT: begin
          w_duty_nxt = '0;
          if (clear_fault) begin
            w_retries_nxt = '0;
            w_state_nxt   = S_IDLE;
          end
        end
        default: begin
          w_duty_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Pin values are derived from next-cycle state so every output is a register.
  assign w_drive_nxt = (w_state_nxt == S_RAMP) || (w_state_nxt == S_RUN);
  assign w_pins_nxt  = w_drive_nxt ? f_pattern(w_dir_nxt) : 4'b0000;
  assign w_en_nxt    = w_drive_nxt && (w_pwm_nxt < w_duty_nxt);
  assign w_fault_nxt = (w_state_nxt == S_FAULT) || (w_state_nxt == S_LOCKOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dir      <= CMD_STOP;
      r_dead_cnt <= '0;
      r_ramp_cnt <= '0;
      r_hold_cnt <= '0;
      r_duty     <= '0;
      r_retries  <= '0;
      r_pwm_cnt  <= '0;
      r_pins     <= '0;
      r_en       <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_dead_cnt <= w_dead_nxt;
      r_ramp_cnt <= w_ramp_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_duty     <= w_duty_nxt;
      r_retries  <= w_retries_nxt;
      r_pwm_cnt  <= w_pwm_nxt;
      r_pins     <= w_pins_nxt;
      r_en       <= w_en_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  assign {OUT1, OUT2, OUT3, OUT4} = r_pins;
  assign OUTA    = r_en;
  assign OUTB    = r_en;
  assign duty    = r_duty;
  assign state   = r_state;
  assign fault   = r_fault;
  assign retries = r_retries;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Directed bench for motor_drive_sequencer with hand-computed expectations.
module tb_motor_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd;
  logic [7:0] duty_target;
  logic       oc_a;
  logic       oc_b;
  logic       clear_fault;
  logic       OUT1, OUT2, OUT3, OUT4, OUTA, OUTB;
  logic [7:0] duty;
  logic [2:0] state;
  logic       fault;
  logic [1:0] retries;

  int checks   = 0;
  int failures = 0;

  int         gap_viol    = 0;
  int         mon_zrun    = 0;
  logic [3:0] mon_last_nz = 4'b0000;
  logic [3:0] pins;

  always #5 clk = ~clk;

  motor_drive_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .duty_target(duty_target),
    .oc_a       (oc_a),
    .oc_b       (oc_b),
    .clear_fault(clear_fault),
    .OUT1       (OUT1),
    .OUT2       (OUT2),
    .OUT3       (OUT3),
    .OUT4       (OUT4),
    .OUTA       (OUTA),
    .OUTB       (OUTB),
    .duty       (duty),
    .state      (state),
    .fault      (fault),
    .retries    (retries)
  );

  assign pins = {OUT1, OUT2, OUT3, OUT4};

  // Every change between two non-zero patterns needs >= 16 all-low samples.
  always @(negedge clk) begin
    if (pins == 4'b0000) begin
      mon_zrun = mon_zrun + 1;
    end else begin
      if (mon_last_nz != 4'b0000 && pins != mon_last_nz && mon_zrun < 16)
        gap_viol = gap_viol + 1;
      mon_last_nz = pins;
      mon_zrun    = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic count_en(input int n, output int hi_a, output int hi_b);
    hi_a = 0;
    hi_b = 0;
    for (int k = 0; k < n; k++) begin
      tick(1);
      if (OUTA) hi_a++;
      if (OUTB) hi_b++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_pins"}, pins, 0);
    chk({tag, "_outab"}, {OUTA, OUTB}, 0);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_retries"}, retries, 0);
  endtask

  int hi_a, hi_b;

  initial begin
    rst = 1'b1; cmd = 2'b00; duty_target = 8'd0;
    oc_a = 1'b0; oc_b = 1'b0; clear_fault = 1'b0;
    tick(2);
    chk_reset_vals("reset");

    // Test 1: FWD soft start to 64
    rst = 1'b0; cmd = 2'b01; duty_target = 8'd64;
    tick(1);
    chk("t1_dead_entry", state, 1);
    chk("t1_dead_pins", pins, 0);
    for (int k = 0; k < 15; k++) begin
      tick(1);
      chk("t1_dead_hold", state, 1);
      chk("t1_dead_hold_pins", pins, 0);
    end
    tick(1);
    chk("t1_ramp_state", state, 2);
    chk("t1_ramp_pins", pins, 4'b1111);
    chk("t1_ramp_duty0", duty, 0);
    chk("t1_duty0_outa", OUTA, 0);
    tick(7);
    chk("t1_before_tick", duty, 0);
    tick(1);
    chk("t1_first_tick", duty, 4);
    tick(119);
    chk("t1_duty60", duty, 60);
    chk("t1_still_ramp", state, 2);
    tick(1);
    chk("t1_duty64", duty, 64);
    chk("t1_run", state, 3);
    count_en(256, hi_a, hi_b);
    chk("t1_pwm64_a", hi_a, 64);
    chk("t1_pwm64_b", hi_b, 64);

    // Test 3: target decrease snaps, increase re-ramps
    duty_target = 8'd20;
    tick(1);
    chk("t3_snap_duty", duty, 20);
    chk("t3_snap_run", state, 3);
    duty_target = 8'd100;
    tick(1);
    chk("t3_reramp_state", state, 2);
    chk("t3_reramp_duty", duty, 20);
    tick(159);
    chk("t3_duty96", duty, 96);
    chk("t3_ramp96", state, 2);
    tick(1);
    chk("t3_duty100", duty, 100);
    chk("t3_run100", state, 3);
    duty_target = 8'd64;
    tick(1);
    chk("t3_back64", duty, 64);

    // Test 2: FWD -> RIGHT while running
    cmd = 2'b10;
    tick(1);
    chk("t2_dead_state", state, 1);
    chk("t2_dead_pins", pins, 0);
    chk("t2_dead_duty", duty, 0);
    chk("t2_dead_outa", OUTA, 0);
    tick(15);
    chk("t2_dead_last", state, 1);
    tick(1);
    chk("t2_ramp_state", state, 2);
    chk("t2_ramp_pins", pins, 4'b0110);
    chk("t2_ramp_duty", duty, 0);

    // Test 4: overcurrent in RAMP, hold, auto-retry
    tick(8);
    chk("t4_pre_duty", duty, 4);
    oc_b = 1'b1;
    tick(1);
    oc_b = 1'b0; cmd = 2'b01;
    chk("t4_fault_state", state, 4);
    chk("t4_fault_outab", {OUTA, OUTB}, 0);
    chk("t4_fault_pins", pins, 0);
    chk("t4_fault_flag", fault, 1);
    chk("t4_fault_retries", retries, 1);
    chk("t4_fault_duty", duty, 0);
    tick(999);
    chk("t4_hold_end", state, 4);
    tick(1);
    chk("t4_idle", state, 0);
    chk("t4_idle_fault", fault, 0);
    chk("t4_idle_retries", retries, 1);
    tick(1);
    chk("t4_restart_dead", state, 1);
    tick(16);
    chk("t4_restart_ramp", state, 2);
    chk("t4_restart_pins", pins, 4'b1111);

    // Test 5: three faults lead to lockout
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_rst_retries", retries, 0);
    chk("t5_rst_state", state, 0);
    tick(1);
    chk("t5_dead", state, 1);
    for (int i = 1; i <= 3; i++) begin
      oc_a = 1'b1;
      tick(1);
      oc_a = 1'b0;
      chk("t5_fault_state", state, 4);
      chk("t5_fault_retries", retries, i);
      chk("t5_fault_flag", fault, 1);
      if (i == 1) begin
        oc_a = 1'b1;
        tick(1);
        oc_a = 1'b0;
        chk("t5_oc_ignored", retries, 1);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        chk("t5_clear_ignored_state", state, 4);
        chk("t5_clear_ignored_retries", retries, 1);
        tick(997);
      end else begin
        tick(999);
      end
      chk("t5_hold_end", state, 4);
      tick(1);
      if (i < 3) begin
        chk("t5_retry_idle", state, 0);
        chk("t5_retry_fault", fault, 0);
        tick(1);
        chk("t5_retry_dead", state, 1);
      end else begin
        chk("t5_lockout", state, 5);
        chk("t5_lockout_fault", fault, 1);
        chk("t5_lockout_retries", retries, 3);
      end
    end
    cmd = 2'b11;
    tick(1);
    chk("t5_lock_cmd_left", state, 5);
    cmd = 2'b00;
    tick(3);
    chk("t5_lock_cmd_stop", state, 5);
    oc_a = 1'b1;
    tick(1);
    oc_a = 1'b0;
    chk("t5_lock_oc_retries", retries, 3);
    chk("t5_lock_pins", pins, 0);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    chk("t5_clear_state", state, 0);
    chk("t5_clear_retries", retries, 0);
    chk("t5_clear_fault", fault, 0);
    tick(1);
    chk("t5_idle_stop", state, 0);

    // Test 6: LEFT, snap-down, rst mid-RAMP, full-scale ramp
    cmd = 2'b11; duty_target = 8'd64;
    tick(1);
    chk("t6_dead", state, 1);
    tick(16);
    chk("t6_ramp", state, 2);
    chk("t6_pins", pins, 4'b1001);
    tick(8);
    chk("t6_duty4", duty, 4);
    duty_target = 8'd2;
    tick(1);
    chk("t6_snap_duty", duty, 2);
    chk("t6_snap_run", state, 3);
    duty_target = 8'd64;
    tick(1);
    chk("t6_reramp", state, 2);
    tick(3);
    rst = 1'b1; oc_a = 1'b1;
    tick(1);
    chk_reset_vals("t6_rst");
    rst = 1'b0; oc_a = 1'b0; duty_target = 8'd255;
    tick(1);
    chk("t6_post_rst_dead", state, 1);
    tick(16);
    chk("t6_post_rst_ramp", state, 2);
    chk("t6_post_rst_pins", pins, 4'b1001);
    chk("t6_post_rst_duty", duty, 0);
    tick(511);
    chk("t6_duty252", duty, 252);
    chk("t6_ramp252", state, 2);
    tick(1);
    chk("t6_duty255", duty, 255);
    chk("t6_run255", state, 3);
    count_en(256, hi_a, hi_b);
    chk("t6_pwm255_a", hi_a, 255);
    chk("t6_pwm255_b", hi_b, 255);
    cmd = 2'b00;
    tick(1);
    chk("t6_stop_state", state, 0);
    chk("t6_stop_duty", duty, 0);
    chk("t6_stop_pins", pins, 0);
    chk("t6_stop_outa", OUTA, 0);

    chk("dead_gap_violations", gap_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_drive_sequencer.md
Name: motor_drive_sequencer

Overview:
Sequences the H-bridge motor driver (OUT1..OUT4 direction pins, OUTA/OUTB enable pins) for the line-following rover. It takes a direction command from the navigation FSM and applies shoot-through dead-time on every direction change. It ramps PWM duty toward a target (soft start) and handles overcurrent faults: lockout, timed auto-retry, and a retry limit. It sits between the navigation controller and the motor driver pins, replacing direct drive of OUT*/OUTA/OUTB.

Parameters:
PWM_BITS, 8, width of the PWM counter and the duty values
DEAD_CYCLES, 16, clocks with all bridge pins low before a new direction is applied
RAMP_STEP, 4, duty increment per ramp tick
RAMP_TICK, 8, clocks between ramp increments
FAULT_HOLD, 1000, clocks held in FAULT before an auto-retry
MAX_RETRIES, 3, faults allowed before permanent LOCKOUT

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cmd  input  2  direction: 00 STOP, 01 FWD, 10 RIGHT, 11 LEFT (level, sampled every clk)
duty_target  input  PWM_BITS  requested PWM duty
oc_a  input  1  overcurrent flag, motor A (synchronous, active-high)
oc_b  input  1  overcurrent flag, motor B
clear_fault  input  1  one-cycle pulse that leaves LOCKOUT
OUT1  output  1  bridge direction pin
OUT2  output  1  bridge direction pin
OUT3  output  1  bridge direction pin
OUT4  output  1  bridge direction pin
OUTA  output  1  motor A PWM enable
OUTB  output  1  motor B PWM enable
duty  output  PWM_BITS  current applied duty
state  output  3  FSM state: 0 IDLE, 1 DEAD, 2 RAMP, 3 RUN, 4 FAULT, 5 LOCKOUT
fault  output  1  high in FAULT and LOCKOUT
retries  output  2  fault count since the last reset or clear_fault

Behaviour:
- All outputs are registered. An input change is visible on outputs the next clk.
- Reset: state=IDLE; OUT1..4=0; OUTA=OUTB=0; duty=0; fault=0; retries=0; PWM counter=0; dead, ramp and hold counters=0.
- Priority each cycle: rst > (oc_a|oc_b) > clear_fault > cmd.
- Direction pattern (OUT1,OUT2,OUT3,OUT4): FWD=1111, RIGHT=0110, LEFT=1001, otherwise 0000.
- PWM counter: free-running, PWM_BITS wide, wraps 255->0.
  - OUTA=OUTB=(pwm_cnt<duty), and only in RAMP or RUN; otherwise 0.
  - duty=0 gives constant low; duty=255 gives high 255 of every 256 clocks.
- IDLE: OUT*=0, duty=0. If cmd!=STOP, latch cmd as dir, load dead counter=DEAD_CYCLES, go to DEAD.
- DEAD: OUT*=0, OUTA/B=0, duty=0. Counter decrements each clk.
  - On reaching 0: drive the pattern for dir, set duty=0, clear the ramp counter, go to RAMP.
  - cmd=STOP during DEAD: go to IDLE.
  - A different non-STOP cmd during DEAD: re-latch dir and reload the counter.
- RAMP: every RAMP_TICK clks, duty = min(duty+RAMP_STEP, duty_target), saturating at 2^PWM_BITS-1.
  - When duty==duty_target, go to RUN.
  - If duty_target falls below duty, duty snaps to duty_target the same cycle, then go to RUN.
- RUN: duty follows decreases in duty_target immediately. An increase returns to RAMP (ramp counter cleared).
- cmd change in RAMP or RUN:
  - STOP: go to IDLE; OUT*=0 and duty=0 next clk.
  - Different direction: OUT*=0, duty=0, re-latch dir, go to DEAD with a full DEAD_CYCLES.
  - Same cmd: no effect.
- Overcurrent: oc_a|oc_b seen in DEAD, RAMP or RUN goes to FAULT next clk.
  - All outputs driven to 0, retries incremented (saturating), hold counter loaded with FAULT_HOLD.
  - oc in IDLE, FAULT or LOCKOUT is ignored.
- FAULT: outputs low; hold counter decrements, and cmd and clear_fault are ignored. At 0:
  - retries<MAX_RETRIES: go to IDLE; a pending cmd restarts via DEAD.
  - retries>=MAX_RETRIES: go to LOCKOUT.
- LOCKOUT: outputs low, fault=1. Only clear_fault (or rst) exits: retries=0, fault=0, go to IDLE.
- Direction pins never switch directly between two non-zero patterns. At least DEAD_CYCLES clocks of 0000 lie between them.
- rst asserted in any state returns to the reset values next clk, regardless of other inputs.

Test Plan:
1. rst, then cmd=FWD, duty_target=64 -> state DEAD for 16 clks with OUT*=0. Then OUT1..4=1111, state RAMP. duty rises 4 every 8 clks and reaches 64 after 128 clks, then state RUN. OUTA is high 64 of every 256 clks.
2. In RUN at duty 64, cmd FWD->RIGHT -> next clk OUT*=0000, duty=0, state DEAD. After 16 clks OUT1..4=0110 and the ramp restarts from 0. No cycle has OUT* go from 1111 to 0110 directly.
3. In RUN at duty 64, duty_target 64->20 -> duty=20 next clk, state stays RUN. Then 20->100 -> state RAMP, duty reaches 100 in 20 ticks (160 clks).
4. In RAMP, pulse oc_b=1 for 1 clk -> next clk state FAULT, OUTA=OUTB=0, OUT*=0, fault=1, retries=1. After 1000 clks state IDLE. With cmd=FWD held, DEAD then RAMP restart.
5. Three overcurrent faults in a row -> after the third hold, state LOCKOUT with fault=1 and retries=3. cmd changes are ignored. A clear_fault pulse gives IDLE, retries=0, fault=0.
6. rst asserted mid-RAMP with oc_a=1 and cmd=LEFT the same clk -> next clk all outputs at reset values and state IDLE. After rst drops, the sequence starts from DEAD.
